// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the MEM stage: holds the pipeline in stall for
// LATENCY cycles per load/store, then commits and presents registered load data.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: the pipeline holds MemRead_i/MemWrite_i and operands steady
  // while stall_o is high; the request is taken on the IDLE edge, and the
  // DONE cycle (stall_o low) is when MEM/WB samples data_o. A request still
  // held during DONE is the one just served and is never taken again.

  state_t          state;
  logic [3:0]      cnt;
  logic            op_write;
  logic [AW-1:0]   idx_lat;
  logic [31:0]     data_lat;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic [AW-1:0]   addr_idx;
  logic            commit;
  logic            commit_write;
  logic [AW-1:0]   commit_idx;
  logic [31:0]     commit_data;

  assign req      = MemRead_i | MemWrite_i;
  assign addr_idx = addr_i[AW+1:2];

  // With LATENCY==1 the commit edge is also the accept edge, so the live
  // inputs stand in for the latched copies that are being captured that edge.
  always_comb begin
    commit       = 1'b0;
    commit_write = op_write;
    commit_idx   = idx_lat;
    commit_data  = data_lat;
    if (!rst_i) begin
      if (state == BUSY && cnt == 4'd1) begin
        commit = 1'b1;
      end else if (state == IDLE && req && LATENCY == 1) begin
        commit       = 1'b1;
        commit_write = MemWrite_i;
        commit_idx   = addr_idx;
        commit_data  = data_i;
      end
    end
  end

  assign stall_o   = !rst_i && ((state == IDLE && req) || state == BUSY);
  assign dbg_state = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_write <= 1'b0;
      idx_lat  <= '0;
      data_lat <= 32'h0;
      data_o   <= 32'h0;
    end else begin
      if (commit && !commit_write) begin
        data_o <= mem[commit_idx];
      end
      case (state)
        IDLE: begin
          if (req) begin
            op_write <= MemWrite_i;
            idx_lat  <= addr_idx;
            data_lat <= data_i;
            if (LATENCY == 1) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            state <= DONE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; a write caught by reset never reaches commit.
  always_ff @(posedge clk_i) begin
    if (commit && commit_write) begin
      mem[commit_idx] <= commit_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, LATENCY=1 and reset corner
// sequences, then random accesses checked against a word-array memory model.
module tb_dmem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd3, wr3, st3;
  logic [31:0] a3, d3, q3;
  logic [1:0]  dbg3;
  logic        rd1, wr1, st1;
  logic [31:0] a1, d1, q1;
  logic [1:0]  dbg1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut3 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd3), .MemWrite_i(wr3),
    .addr_i(a3), .data_i(d3), .data_o(q3), .stall_o(st3), .dbg_state(dbg3)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(a1), .data_i(d1), .data_o(q1), .stall_o(st1), .dbg_state(dbg1)
  );

  // scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_q;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          scramble;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Drives one request on the LATENCY=3 port, counts stalled cycles and
  // returns data_o as seen in the first unstalled (DONE) cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input bit scramble,
                           output int nst, output logic [31:0] q);
    rd3 = rd; wr3 = wr; a3 = a; d3 = d; nst = 0;
    @(negedge clk);
    while (st3 && nst < 40) begin
      nst++;
      @(posedge clk); #1;
      if (scramble) begin
        a3 = $urandom;
        d3 = $urandom;
      end
      @(negedge clk);
    end
    q = q3;
    @(posedge clk); #1;
    rd3 = 1'b0; wr3 = 1'b0;
  endtask

  // Transaction-level expectation: a store only touches the array, a load
  // (store flag clear) returns the array word and becomes the held output.
  task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d);
    if (wr) model_mem[widx(a)] = d;
    else if (rd) model_q = model_mem[widx(a)];
  endtask

  initial begin
    int          nst;
    logic [31:0] q;
    logic [31:0] v;
    int          op;

    rst = 1'b1;
    rd3 = 1'b1; wr3 = 1'b0; a3 = 32'h0; d3 = 32'h0;
    rd1 = 1'b0; wr1 = 1'b0; a1 = 32'h0; d1 = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      v = 32'h1000_0000 + 32'(i) * 32'h0001_0307;
      dut3.mem[i] = v;
      dut1.mem[i] = ~v;
      model_mem[i] = v;
    end
    dut3.mem[5] = 32'hDEAD_BEEF; model_mem[5] = 32'hDEAD_BEEF;
    dut3.mem[7] = 32'hAAAA_AAAA; model_mem[7] = 32'hAAAA_AAAA;
    dut1.mem[0] = 32'h0000_1111;
    dut1.mem[1] = 32'h0000_2222;
    model_q = 32'h0;

    // reset state, request held during reset must not stall
    #1;
    check("reset_stall", {31'b0, st3}, 32'h0);
    check("reset_data", q3, 32'h0);
    check("reset_data_lat1", q1, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; rd3 = 1'b0;

    // LATENCY=1: back-to-back reads of mem[0], mem[1] in 4 cycles
    rd1 = 1'b1; a1 = 32'h0;
    @(negedge clk); check("lat1_c0_stall", {31'b0, st1}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk); check("lat1_c1_stall", {31'b0, st1}, 32'h0);
    check("lat1_c1_data", q1, 32'h0000_1111);
    @(posedge clk); #1; a1 = 32'h4;
    @(negedge clk); check("lat1_c2_stall", {31'b0, st1}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk); check("lat1_c3_stall", {31'b0, st1}, 32'h0);
    check("lat1_c3_data", q1, 32'h0000_2222);
    @(posedge clk); #1; rd1 = 1'b0;
    @(negedge clk); check("lat1_hold", q1, 32'h0000_2222);
    @(posedge clk); #1;

    // directed vector table on the LATENCY=3 port
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,          1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0408, 32'h1234_5678,  1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          1'b0, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_001C, 32'h0,          1'b0, 32'hAAAA_AAAA};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0005,  1'b0, 32'hAAAA_AAAA};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_000B, 32'h0,          1'b0, 32'h0000_0005};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D,  1'b1, 32'h0000_0005};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,          1'b0, 32'hCAFE_F00D};
    vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FC14, 32'h0,          1'b0, 32'hDEAD_BEEF};
    for (int i = 0; i < 9; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].scramble, nst, q);
      model_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
      check($sformatf("vec%0d_stalls", i), 32'(nst), 32'(LAT));
      check($sformatf("vec%0d_data", i), q, vecs[i].exp_data);
      @(negedge clk);
      check($sformatf("vec%0d_idle_stall", i), {31'b0, st3}, 32'h0);
      check($sformatf("vec%0d_hold", i), q3, vecs[i].exp_data);
      @(posedge clk); #1;
    end

    // reset during the second BUSY cycle of a write
    wr3 = 1'b1; a3 = 32'h0000_0024; d3 = 32'h0BAD_0BAD;
    @(negedge clk); check("rstw_c0_stall", {31'b0, st3}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstw_busy_stall", {31'b0, st3}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstw_async_stall", {31'b0, st3}, 32'h0);
    check("rstw_async_data", q3, 32'h0);
    @(posedge clk); #1;
    wr3 = 1'b0; rst = 1'b0; model_q = 32'h0;
    do_access(1'b1, 1'b0, 32'h0000_0024, 32'h0, 1'b0, nst, q);
    model_access(1'b1, 1'b0, 32'h0000_0024, 32'h0);
    check("rstw_after_stalls", 32'(nst), 32'(LAT));
    check("rstw_word_kept", q, model_mem[9]);

    // randomized accesses, including idle cycles and back-to-back requests
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 3);
      a3 = $urandom;
      d3 = $urandom;
      if (op == 0) begin
        rd3 = 1'b0; wr3 = 1'b0;
        @(negedge clk);
        check("rnd_idle_stall", {31'b0, st3}, 32'h0);
        check("rnd_idle_hold", q3, model_q);
        @(posedge clk); #1;
      end else begin
        logic r, w;
        logic [31:0] ra, rdat;
        r = (op == 1) || (op == 3);
        w = (op == 2) || (op == 3);
        ra = (it % 4 == 0) ? {$urandom_range(0, 7), 24'h0, 6'($urandom_range(0, 15)), 2'b00} : a3;
        rdat = d3;
        model_access(r, w, ra, rdat);
        exp_q.push_back(model_q);
        do_access(r, w, ra, rdat, bit'($urandom_range(0, 1)), nst, q);
        check("rnd_stalls", 32'(nst), 32'(LAT));
        check("rnd_data", q, exp_q.pop_front());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
